// File: rtl/ipsxe_floating_point_stim_pkg.sv
// ----------------------------------------------------------------------------
// ipsxe_floating_point_stim_pkg
// Shared definitions for the floating-point stimulus sequencer.
//   ADDR_W  : width of the external vector-ROM address bus (16 entries max)
//   state_e : sequencer state encoding
// ----------------------------------------------------------------------------
package ipsxe_floating_point_stim_pkg;

   localparam int ADDR_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_CAP  = 3'd2,
      ST_SEND = 3'd3,
      ST_DONE = 3'd4
   } state_e;

endpackage

// File: rtl/ipsxe_floating_point_stim_seq.sv
// ----------------------------------------------------------------------------
// ipsxe_floating_point_stim_seq
// Walks an external vector ROM and presents each entry as an operand to a
// downstream floating-point core over a valid/ready handshake.
//
// Parameters
//   EXP_WIDTH : exponent field width of each vector
//   MAN_WIDTH : mantissa field width of each vector
//   NUM_VEC   : ROM entries walked per pass (1..16)
//
// Ports
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   start     : begin a pass (only honoured while idle)
//   abort     : synchronous cancel of the current pass
//   rd_addr   : vector-ROM read address
//   rom_dout  : registered ROM data, valid one edge after rd_addr
//   m_tvalid  : operand valid
//   m_tready  : downstream ready
//   m_tdata   : operand {sign, exponent, mantissa}
//   busy      : pass in progress (RD, CAP, SEND)
//   done      : one-cycle pulse at the end of a pass
//   vec_cnt   : accepted transfers in the current/last pass (saturating)
//   loop_mode : only with IPSXE_FLOATING_POINT_STIM_LOOP_EN defined; when set
//               the pass wraps to address 0 instead of finishing
//
// Build option
//   IPSXE_FLOATING_POINT_STIM_LOOP_EN : adds the loop_mode port
// ----------------------------------------------------------------------------
module ipsxe_floating_point_stim_seq
   import ipsxe_floating_point_stim_pkg::*;
#(
   parameter int EXP_WIDTH = 8,
   parameter int MAN_WIDTH = 23,
   parameter int NUM_VEC   = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic                           abort,
   output logic [ADDR_W-1:0]              rd_addr,
   input  logic [EXP_WIDTH+MAN_WIDTH:0]   rom_dout,
   output logic                           m_tvalid,
   input  logic                           m_tready,
   output logic [EXP_WIDTH+MAN_WIDTH:0]   m_tdata,
   output logic                           busy,
   output logic                           done,
`ifdef IPSXE_FLOATING_POINT_STIM_LOOP_EN
   input  logic                           loop_mode,
`endif
   output logic [15:0]                    vec_cnt
);

   localparam int                 DATA_W    = 1 + EXP_WIDTH + MAN_WIDTH;
   localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(NUM_VEC - 1);
   localparam logic [ADDR_W-1:0]  ADDR_ONE  = ADDR_W'(1);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q,  addr_d;
   logic                tvalid_q, tvalid_d;
   logic [DATA_W-1:0]   tdata_q, tdata_d;
   logic [15:0]         cnt_q,   cnt_d;

   logic                hs;
   logic                last_vec;
   logic                loop_wrap;
   logic                abort_act;

   assign hs        = tvalid_q & m_tready;
   assign last_vec  = (addr_q == LAST_ADDR);
   // abort has no meaning while idle, so start is never blocked by it there
   assign abort_act = abort & (state_q != ST_IDLE);

`ifdef IPSXE_FLOATING_POINT_STIM_LOOP_EN
   assign loop_wrap = loop_mode;
`else
   assign loop_wrap = 1'b0;
`endif

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (start) state_d = ST_RD;
         ST_RD:   state_d = ST_CAP;   // ROM latency cycle
         ST_CAP:  state_d = ST_SEND;
         ST_SEND: begin
            if (hs) begin
               state_d = (last_vec && !loop_wrap) ? ST_DONE : ST_RD;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (abort_act) begin
         state_d = ST_IDLE;
      end
   end

   // ---------------------------------------------------------------------
   // Output decode
   // ---------------------------------------------------------------------
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      unique case (state_q)
         ST_RD, ST_CAP, ST_SEND: busy = 1'b1;
         ST_DONE:                done = 1'b1;
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath next values: address, operand register, transfer counter
   // ---------------------------------------------------------------------
   always_comb begin
      addr_d   = addr_q;
      tvalid_d = tvalid_q;
      tdata_d  = tdata_q;
      cnt_d    = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               addr_d = '0;
               cnt_d  = '0;
            end
         end
         ST_CAP: begin
            tdata_d  = rom_dout;
            tvalid_d = 1'b1;
         end
         ST_SEND: begin
            if (hs) begin
               tvalid_d = 1'b0;
               if (cnt_q != 16'hFFFF) begin
                  cnt_d = cnt_q + 16'd1;
               end
               if (!last_vec) begin
                  addr_d = addr_q + ADDR_ONE;
               end else if (loop_wrap) begin
                  addr_d = '0;
               end
            end
         end
         default: ;
      endcase
      // abort wins over a simultaneous handshake: nothing is counted or advanced
      if (abort_act) begin
         addr_d   = addr_q;
         tvalid_d = 1'b0;
         tdata_d  = tdata_q;
         cnt_d    = cnt_q;
      end
   end

   // ---------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q   <= '0;
         tvalid_q <= 1'b0;
         tdata_q  <= '0;
         cnt_q    <= '0;
      end else begin
         addr_q   <= addr_d;
         tvalid_q <= tvalid_d;
         tdata_q  <= tdata_d;
         cnt_q    <= cnt_d;
      end
   end

   assign rd_addr  = addr_q;
   assign m_tvalid = tvalid_q;
   assign m_tdata  = tdata_q;
   assign vec_cnt  = cnt_q;

endmodule

// File: tb/tb_ipsxe_floating_point_stim_seq.sv
// ----------------------------------------------------------------------------
// tb_ipsxe_floating_point_stim_seq
// Bench for the stimulus sequencer with NUM_VEC=4 and default widths.
// An external registered ROM model feeds rom_dout. A pass-level reference
// model (current vector index, cycles until the next operand appears,
// accepted count, pending done pulse) predicts every output after each edge.
// ----------------------------------------------------------------------------
module tb_ipsxe_floating_point_stim_seq;

   localparam int EW = 8;
   localparam int MW = 23;
   localparam int NV = 4;
   localparam int DW = 1 + EW + MW;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          abort;
   logic [3:0]    rd_addr;
   logic [DW-1:0] rom_dout;
   logic          m_tvalid;
   logic          m_tready;
   logic [DW-1:0] m_tdata;
   logic          busy;
   logic          done;
   logic [15:0]   vec_cnt;
   bit            loop_on;

   logic [DW-1:0] rom [16];
   logic [DW-1:0] exp_tbl [4];

   int checks   = 0;
   int failures = 0;

   // reference model
   bit  m_active;
   bit  m_valid;
   bit  m_done;
   int  m_gap;
   int  m_idx;
   int  m_cnt;

   int            cyc_no;
   int            done_total;
   int            done_cyc;
   int            hs_total;
   logic [DW-1:0] acc_q [$];
   int            hs_cyc_q [$];
   int            addr_log [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // external vector ROM: one-cycle registered read
   always @(posedge clk) rom_dout <= rom[rd_addr];

   ipsxe_floating_point_stim_seq #(
      .EXP_WIDTH (EW),
      .MAN_WIDTH (MW),
      .NUM_VEC   (NV)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .rd_addr   (rd_addr),
      .rom_dout  (rom_dout),
      .m_tvalid  (m_tvalid),
      .m_tready  (m_tready),
      .m_tdata   (m_tdata),
      .busy      (busy),
      .done      (done),
`ifdef IPSXE_FLOATING_POINT_STIM_LOOP_EN
      .loop_mode (loop_on),
`endif
      .vec_cnt   (vec_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      m_active = 1'b0;
      m_valid  = 1'b0;
      m_done   = 1'b0;
      m_gap    = 0;
      m_idx    = 0;
      m_cnt    = 0;
   endtask

   // Drive one cycle of inputs, predict the effect of the coming edge,
   // then compare every output on the following falling edge.
   task automatic cycle(input bit st, input bit tr, input bit ab);
      start    = st;
      m_tready = tr;
      abort    = ab;
      if (m_active && ab) begin
         m_active = 1'b0;
         m_valid  = 1'b0;
         m_done   = 1'b0;
         m_gap    = 0;
      end else if (m_done) begin
         m_done   = 1'b0;
         m_active = 1'b0;
      end else if (!m_active) begin
         if (st) begin
            m_active = 1'b1;
            m_idx    = 0;
            m_cnt    = 0;
            m_gap    = 2;
            m_valid  = 1'b0;
         end
      end else if (m_valid) begin
         if (tr) begin
            acc_q.push_back(m_tdata);
            hs_cyc_q.push_back(cyc_no);
            addr_log.push_back(m_idx);
            hs_total++;
            if (m_cnt < 65535) m_cnt++;
            m_valid = 1'b0;
            if (m_idx == NV - 1) begin
               if (loop_on) begin
                  m_idx = 0;
                  m_gap = 2;
               end else begin
                  m_done = 1'b1;
               end
            end else begin
               m_idx++;
               m_gap = 2;
            end
         end
      end else if (m_gap > 0) begin
         m_gap--;
         if (m_gap == 0) m_valid = 1'b1;
      end
      @(negedge clk);
      cyc_no++;
      chk("tvalid",  32'(m_tvalid), 32'(m_valid));
      chk("done",    32'(done),     32'(m_done));
      chk("busy",    32'(busy),     32'(m_active && !m_done));
      chk("vec_cnt", 32'(vec_cnt),  m_cnt);
      chk("rd_addr", 32'(rd_addr),  m_idx);
      if (m_valid) chk("tdata", m_tdata, rom[m_idx]);
      if (done) begin
         done_total++;
         done_cyc = cyc_no;
      end
   endtask

   task automatic run(input int n, input bit tr);
      for (int k = 0; k < n; k++) cycle(1'b0, tr, 1'b0);
   endtask

   // apply reset at the current point in time and check outputs at once
   task automatic do_reset();
      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      #1;
      chk("rst_rd_addr", 32'(rd_addr),  32'd0);
      chk("rst_tvalid",  32'(m_tvalid), 32'd0);
      chk("rst_tdata",   m_tdata,       32'd0);
      chk("rst_busy",    32'(busy),     32'd0);
      chk("rst_done",    32'(done),     32'd0);
      chk("rst_vec_cnt", 32'(vec_cnt),  32'd0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic clear_logs();
      acc_q.delete();
      hs_cyc_q.delete();
      addr_log.delete();
      done_total = 0;
      done_cyc   = -1;
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      abort    = 1'b0;
      m_tready = 1'b0;
      loop_on  = 1'b0;
      cyc_no   = 0;
      hs_total = 0;
      for (int i = 0; i < 16; i++) rom[i] = '0;
      rom[0] = 32'h40800000;
      rom[1] = 32'h7FC00000;
      rom[2] = 32'h7F800000;
      rom[3] = 32'h00000000;
      for (int i = 0; i < 4; i++) exp_tbl[i] = rom[i];
      model_reset();
      clear_logs();
      @(negedge clk);
      do_reset();
      run(2, 1'b1);

      // full pass, downstream always ready
      clear_logs();
      cycle(1'b1, 1'b1, 1'b0);
      run(20, 1'b1);
      chk("p1_hs_count", 32'(acc_q.size()), 32'd4);
      for (int i = 0; i < 4 && i < acc_q.size(); i++) chk("p1_seq", acc_q[i], exp_tbl[i]);
      for (int i = 0; i + 1 < hs_cyc_q.size(); i++)
         chk("p1_spacing", 32'(hs_cyc_q[i+1] - hs_cyc_q[i]), 32'd3);
      chk("p1_done_count", 32'(done_total), 32'd1);
      if (hs_cyc_q.size() == 4) chk("p1_done_time", 32'(done_cyc), 32'(hs_cyc_q[3] + 1));
      chk("p1_vec_cnt", 32'(vec_cnt), 32'd4);

      // back-pressure on vector 1
      clear_logs();
      cycle(1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 30 && !(m_valid && m_idx == 1); k++) cycle(1'b0, 1'b1, 1'b0);
      chk("bp_reach", {27'd0, m_tvalid, rd_addr}, {27'd0, 1'b1, 4'd1});
      for (int k = 0; k < 5; k++) begin
         cycle(1'b0, 1'b0, 1'b0);
         chk("bp_hold_valid", 32'(m_tvalid), 32'd1);
         chk("bp_hold_data",  m_tdata,       32'h7FC00000);
      end
      chk("bp_cnt_before", 32'(vec_cnt), 32'd1);
      cycle(1'b0, 1'b1, 1'b0);
      chk("bp_cnt_after", 32'(vec_cnt), 32'd2);
      run(20, 1'b1);
      chk("bp_vec_cnt", 32'(vec_cnt), 32'd4);

      // start re-asserted while vector 2 is being sent
      clear_logs();
      cycle(1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 30 && !(m_valid && m_idx == 2); k++) cycle(1'b0, 1'b1, 1'b0);
      chk("rs_reach", {27'd0, m_tvalid, rd_addr}, {27'd0, 1'b1, 4'd2});
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b0);
      run(20, 1'b1);
      chk("rs_vec_cnt", 32'(vec_cnt), 32'd4);
      chk("rs_done_count", 32'(done_total), 32'd1);

      // reset while vector 1 is being sent
      clear_logs();
      cycle(1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 30 && !(m_valid && m_idx == 1); k++) cycle(1'b0, 1'b1, 1'b0);
      chk("rst_reach", {27'd0, m_tvalid, rd_addr}, {27'd0, 1'b1, 4'd1});
      do_reset();
      run(6, 1'b1);
      chk("rst_no_xfer", 32'(acc_q.size()), 32'd1);
      cycle(1'b1, 1'b1, 1'b0);
      chk("rst_restart_addr", 32'(rd_addr), 32'd0);
      run(20, 1'b1);
      chk("rst_vec_cnt", 32'(vec_cnt), 32'd4);

      // abort coinciding with the handshake of vector 3
      clear_logs();
      cycle(1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 30 && !(m_valid && m_idx == 3); k++) cycle(1'b0, 1'b1, 1'b0);
      chk("ab_reach", {27'd0, m_tvalid, rd_addr}, {27'd0, 1'b1, 4'd3});
      cycle(1'b0, 1'b1, 1'b1);
      chk("ab_busy", 32'(busy), 32'd0);
      chk("ab_done", 32'(done), 32'd0);
      chk("ab_vec_cnt", 32'(vec_cnt), 32'd3);
      run(6, 1'b1);
      chk("ab_done_count", 32'(done_total), 32'd0);

      // randomized passes with random ROM contents, ready, start and abort
      for (int p = 0; p < 8; p++) begin
         if (!m_active) begin
            for (int i = 0; i < NV; i++) rom[i] = DW'($urandom);
         end
         for (int k = 0; k < 50; k++) begin
            cycle(($urandom_range(3) == 0), ($urandom_range(2) != 0), ($urandom_range(31) == 0));
         end
         run(20, 1'b1);
      end

`ifdef IPSXE_FLOATING_POINT_STIM_LOOP_EN
      // loop mode: ten handshakes wrap through the ROM without a done pulse
      rom[0] = 32'h40800000;
      rom[1] = 32'h7FC00000;
      rom[2] = 32'h7F800000;
      rom[3] = 32'h00000000;
      clear_logs();
      loop_on = 1'b1;
      cycle(1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 60 && addr_log.size() < 10; k++) cycle(1'b0, 1'b1, 1'b0);
      chk("loop_hs_count", 32'(addr_log.size()), 32'd10);
      for (int i = 0; i < addr_log.size(); i++) chk("loop_addr", 32'(addr_log[i]), 32'(i % 4));
      chk("loop_done_count", 32'(done_total), 32'd0);
      cycle(1'b0, 1'b1, 1'b1);
      loop_on = 1'b0;
      run(4, 1'b1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
